rob_multi_wb: RTL
=================

// Module: rob_multi_wb
// PURPOSE
//  Parametrised reorder buffer. Successor to the single-writeback ROB.
//  - Accepts in-order issue from the decoder and NUM_WB out-of-order writebacks (RS, LSB, ...).
//  - Retires one entry per cycle in order, to the regfile.
//  - Counter-based full/empty, store-commit handshake with the LSB, branch-mispredict flush with a redirect PC.
//  - Serves two operand-search ports with same-cycle writeback forwarding.
// PARAMETERS
//  DEPTH   16  entries; power of two, >=4
//  AW      4   log2(DEPTH); rob_id width
//  NUM_WB  2   writeback ports; port 0 = RS, port 1 = LSB
// PORTS
//  clk_in              in   1          system clock
//  rst_in              in   1          synchronous, active-high reset
//  rdy_in              in   1          low = hold all state and outputs
//  issue_valid         in   1          decoder presents an instruction
//  issue_ready         out  1          !full && !flush
//  issue_rob_id        out  AW         tail index assigned to the issuing instruction
//  issue_type          in   3          codebase type encoding (`B, `S, other)
//  issue_rd            in   5          destination register
//  issue_val           in   32         preset value (e.g. link address); ready if issue_done
//  issue_done          in   1          entry is complete at issue (no writeback expected)
//  issue_pred          in   32         branch: predicted next PC
//  wb_valid            in   NUM_WB     per-port writeback strobe
//  wb_rob_id           in   NUM_WB*AW  flattened; port k at [k*AW +: AW]
//  wb_value            in   NUM_WB*32  flattened; branch: resolved next PC
//  commit_valid        out  1          one-cycle pulse, registered
//  commit_rob_id       out  AW         retired entry index
//  commit_rd           out  5          retired destination register
//  commit_val          out  32         retired value
//  store_commit_valid  out  1          head is a ready store; level, held until ack
//  store_commit_rob_id out  AW         = head
//  store_commit_ack    in   1          LSB has performed the store
//  flush               out  1          one-cycle pulse, registered; mispredict
//  flush_pc            out  32         redirect target, valid with flush
//  search_id_1/2       in   AW         operand source tag
//  search_ready_1/2    out  1          tag value available
//  search_val_1/2      out  32         tag value
//  count               out  AW+1       occupancy; rob_empty = count==0, rob_full = count==DEPTH
// BEHAVIOUR
//  - Reset: head=tail=count=0; all valid/ready bits 0; commit_valid=0, flush=0, flush_pc=0; rob ids 0.
//    Reset mid-operation discards every entry, including a store awaiting ack.
//  - Issue: accepted when issue_valid && issue_ready.
//    - Writes entry[tail]: valid=1, ready=issue_done.
//    - tail wraps DEPTH-1 -> 0.
//  - Writeback: wb_valid[k] sets ready=1 and value=wb_value[k] for entry wb_rob_id[k].
//    - Ignored if that entry is not valid.
//    - Two ports writing the same id in one cycle is illegal; higher k wins.
//  - Retire: at most one per cycle, head entry only, when valid && ready.
//    - Non-branch, non-store: commit_valid=1 next cycle with id/rd/val; entry freed; head+1.
//    - Store: store_commit_valid=1 combinationally; no regfile commit.
//      Retires in the cycle store_commit_ack=1. An ack while store_commit_valid=0 is ignored.
//    - Branch: freed without commit_valid. If value != pred: flush=1 and flush_pc=value next cycle.
//  - Flush:
//    - In the cycle flush=1 (and rdy_in), all entries are invalidated and head=tail=count=0.
//    - Issue and writeback are ignored in that cycle. issue_ready=0 while flush=1.
//    - No retire follows a mispredicting branch until the flush has taken effect.
//  - count: +1 on issue, -1 on retire. Simultaneous issue and retire leaves it unchanged.
//    - Issue at full is impossible because issue_ready=0.
//    - Retire at empty is impossible because the head entry is not valid.
//  - Search: ready = entry ready, or any wb_valid[k] with a matching id this cycle (forwarded value).
//    Forwarding takes priority over the stored value.
//  - rdy_in=0: no state change; registered outputs hold; acks are ignored.
// TESTING
//  - Fill: DEPTH issues with issue_done=0 -> count=16, issue_ready=0.
//    Writeback id 0 on port 0 -> commit_valid next cycle with commit_rob_id=0; issue_ready=1.
//  - Wrap-around: 20 issue/retire pairs with 1 in flight ->
//    - ids 0..15,0..3 in order;
//    - count stays 1;
//    - simultaneous issue+retire keeps count.
//  - Out-of-order writeback: issue A,B,C; writeback C, B, then A ->
//    three commit pulses in order A,B,C on consecutive cycles.
//  - Store: head store ready, ack held 0 for 5 cycles ->
//    store_commit_valid held and head unchanged; ack=1 -> retires; no commit_valid.
//  - Mispredict: branch with pred=0x100 and wb value 0x200, 3 younger entries ->
//    flush=1, flush_pc=0x200; the cycle after, count=0 and no younger commit_valid.
//  - Forwarding and hold: search_id_1=5 while wb writes id 5=0xDEAD -> search_ready_1=1, val 0xDEAD the same cycle.
//    rdy_in=0 for 3 cycles -> no state change.

Source files
------------

// File: rtl/rob_multi_wb.sv
// Reorder buffer with NUM_WB out-of-order writeback ports, in-order single retire,
// store-commit handshake, mispredict flush and two forwarding operand-search ports.
module rob_multi_wb #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned NUM_WB = 2,
  parameter logic [2:0]  TYPE_B = 3'd1,
  parameter logic [2:0]  TYPE_S = 3'd2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  output logic [AW-1:0]          issue_rob_id,
  input  logic [2:0]             issue_type,
  input  logic [4:0]             issue_rd,
  input  logic [31:0]            issue_val,
  input  logic                   issue_done,
  input  logic [31:0]            issue_pred,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*AW-1:0]   wb_rob_id,
  input  logic [NUM_WB*32-1:0]   wb_value,
  output logic                   commit_valid,
  output logic [AW-1:0]          commit_rob_id,
  output logic [4:0]             commit_rd,
  output logic [31:0]            commit_val,
  output logic                   store_commit_valid,
  output logic [AW-1:0]          store_commit_rob_id,
  input  logic                   store_commit_ack,
  output logic                   flush,
  output logic [31:0]            flush_pc,
  input  logic [AW-1:0]          search_id_1,
  input  logic [AW-1:0]          search_id_2,
  output logic                   search_ready_1,
  output logic                   search_ready_2,
  output logic [31:0]            search_val_1,
  output logic [31:0]            search_val_2,
  output logic [AW:0]            count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [2:0]       type_q [DEPTH];
  logic [2:0]       type_d [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      val_q  [DEPTH];
  logic [31:0]      val_d  [DEPTH];
  logic [31:0]      pred_q [DEPTH];
  logic [31:0]      pred_d [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic          commit_valid_q, commit_valid_d;
  logic [AW-1:0] commit_rob_id_q, commit_rob_id_d;
  logic [4:0]    commit_rd_q, commit_rd_d;
  logic [31:0]   commit_val_q, commit_val_d;
  logic          flush_q, flush_d;
  logic [31:0]   flush_pc_q, flush_pc_d;

  logic [AW-1:0] wb_id  [NUM_WB];
  logic [31:0]   wb_val [NUM_WB];

  logic head_done, head_is_br, head_is_st;
  logic do_issue, do_retire, mispredict;

  logic [AW-1:0] sid  [2];
  logic          srdy [2];
  logic [31:0]   sval [2];

  for (genvar g = 0; g < NUM_WB; g++) begin : g_wb
    assign wb_id[g]  = wb_rob_id[g*AW +: AW];
    assign wb_val[g] = wb_value[g*32 +: 32];
  end

  assign issue_ready  = (count_q != (AW+1)'(DEPTH)) && !flush_q;
  assign issue_rob_id = tail_q;

  // Head is blocked while a flush is pending so nothing younger than a mispredict retires.
  assign head_done  = valid_q[head_q] && ready_q[head_q] && !flush_q;
  assign head_is_br = (type_q[head_q] == TYPE_B);
  assign head_is_st = (type_q[head_q] == TYPE_S);

  assign store_commit_valid  = head_done && head_is_st;
  assign store_commit_rob_id = head_q;

  assign do_issue   = issue_valid && issue_ready;
  assign do_retire  = head_done && (!head_is_st || store_commit_ack);
  assign mispredict = do_retire && head_is_br && (val_q[head_q] != pred_q[head_q]);

  always_comb begin
    valid_d         = valid_q;
    ready_d         = ready_q;
    type_d          = type_q;
    rd_d            = rd_q;
    val_d           = val_q;
    pred_d          = pred_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    commit_valid_d  = 1'b0;
    commit_rob_id_d = commit_rob_id_q;
    commit_rd_d     = commit_rd_q;
    commit_val_d    = commit_val_q;
    flush_d         = 1'b0;
    flush_pc_d      = flush_pc_q;

    if (flush_q) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Later ports overwrite earlier ones when ids collide.
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && valid_q[wb_id[k]]) begin
          ready_d[wb_id[k]] = 1'b1;
          val_d[wb_id[k]]   = wb_val[k];
        end
      end

      if (do_issue) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = issue_done;
        type_d[tail_q]  = issue_type;
        rd_d[tail_q]    = issue_rd;
        val_d[tail_q]   = issue_val;
        pred_d[tail_q]  = issue_pred;
        tail_d          = tail_q + AW'(1);
      end

      if (do_retire) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + AW'(1);
        if (head_is_br) begin
          if (mispredict) begin
            flush_d    = 1'b1;
            flush_pc_d = val_q[head_q];
          end
        end else if (!head_is_st) begin
          commit_valid_d  = 1'b1;
          commit_rob_id_d = head_q;
          commit_rd_d     = rd_q[head_q];
          commit_val_d    = val_q[head_q];
        end
      end

      unique case ({do_issue, do_retire})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
      ready_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        type_q[i] <= '0;
        rd_q[i]   <= '0;
        val_q[i]  <= '0;
        pred_q[i] <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_valid_q  <= 1'b0;
      commit_rob_id_q <= '0;
      commit_rd_q     <= '0;
      commit_val_q    <= '0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
    end else if (rdy_in) begin
      valid_q         <= valid_d;
      ready_q         <= ready_d;
      type_q          <= type_d;
      rd_q            <= rd_d;
      val_q           <= val_d;
      pred_q          <= pred_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_valid_q  <= commit_valid_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_rd_q     <= commit_rd_d;
      commit_val_q    <= commit_val_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
    end
  end

  assign sid[0] = search_id_1;
  assign sid[1] = search_id_2;

  // Same-cycle writeback forwarding takes priority over the stored value.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      srdy[p] = ready_q[sid[p]];
      sval[p] = val_q[sid[p]];
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_id[k] == sid[p])) begin
          srdy[p] = 1'b1;
          sval[p] = wb_val[k];
        end
      end
    end
  end

  assign search_ready_1 = srdy[0];
  assign search_val_1   = sval[0];
  assign search_ready_2 = srdy[1];
  assign search_val_2   = sval[1];

  assign commit_valid  = commit_valid_q;
  assign commit_rob_id = commit_rob_id_q;
  assign commit_rd     = commit_rd_q;
  assign commit_val    = commit_val_q;
  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;
  assign count         = count_q;

endmodule
